// File: rtl/rank_select.sv
// rank_select: selects the rank-th smallest of N unsigned elements via odd-even transposition sort; RANK_SELECT_MINMAX_EN adds out_min/out_max
module rank_select #(
  parameter int N  = 9,
  parameter int W  = 8,
  parameter int RW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] inp,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [RW-1:0]  rank,
  output logic [W-1:0]   out,
  output logic           out_valid
`ifdef RANK_SELECT_MINMAX_EN
  ,
  output logic [W-1:0]   out_min,
  output logic [W-1:0]   out_max
`endif
);
  localparam int PW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  state_t          state_q, state_d;
  logic [W-1:0]    data_q [N];
  logic [W-1:0]    data_d [N];
  logic [RW-1:0]   rank_q, rank_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [W-1:0]    out_q, out_d;
  logic            out_valid_q, out_valid_d;
`ifdef RANK_SELECT_MINMAX_EN
  logic [W-1:0]    min_q, min_d, max_q, max_d;
  assign out_min = min_q;
  assign out_max = max_q;
`endif
  assign in_ready  = state_q == IDLE;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  // capture on accept, one transposition phase per SORT cycle, publish the selected element from DONE
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rank_d      = rank_q;
    phase_d     = phase_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
`ifdef RANK_SELECT_MINMAX_EN
    min_d       = min_q;
    max_d       = max_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        for (int i = 0; i < N; i++) data_d[i] = inp[i*W +: W];
        rank_d  = ({1'b0, rank} >= (RW+1)'(N)) ? RW'(N - 1) : rank;
        phase_d = '0;
        state_d = SORT;
      end
      SORT: begin
        for (int i = 0; i < N - 1; i++)
          if ((i % 2) == int'(phase_q[0]) && data_q[i] > data_q[i+1]) begin
            data_d[i]   = data_q[i+1];
            data_d[i+1] = data_q[i];
          end
        phase_d = phase_q + 1'b1;
        state_d = (phase_q == PW'(N - 1)) ? DONE : SORT;
      end
      DONE: begin
        out_d       = data_q[rank_q];
        out_valid_d = 1'b1;
`ifdef RANK_SELECT_MINMAX_EN
        min_d       = data_q[0];
        max_d       = data_q[N-1];
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < N; i++) data_q[i] <= '0;
      rank_q      <= '0;
      phase_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef RANK_SELECT_MINMAX_EN
      min_q       <= '0;
      max_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rank_q      <= rank_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef RANK_SELECT_MINMAX_EN
      min_q       <= min_d;
      max_q       <= max_d;
`endif
    end
  end
endmodule

// File: tb/tb_rank_select.sv
// tb_rank_select: directed scoreboard bench for rank_select (N=9, W=8)
module tb_rank_select;
  localparam int N  = 9;
  localparam int W  = 8;
  localparam int RW = 4;
  localparam logic [N*W-1:0] MED  = 72'hC9E1D5C1B361D4AAF0;
  localparam logic [N*W-1:0] DUP  = 72'h7F7F7F7F7F007F7F7F;
  localparam logic [N*W-1:0] JUNK = 72'h0102030405060708FF;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] inp = '0;
  logic [RW-1:0]  rank = '0;
  logic [W-1:0]   out;
  logic           out_valid;
`ifdef RANK_SELECT_MINMAX_EN
  logic [W-1:0]   out_min, out_max;
`endif
  int vectors = 0;
  int miscompares = 0;
  logic [23:0] exp_q [$];
  int seen, t1, t2;
  always #5 clk = ~clk;
  rank_select #(.N(N), .W(W), .RW(RW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inp(inp),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .rank(rank),
    .out(out),
    .out_valid(out_valid)
`ifdef RANK_SELECT_MINMAX_EN
    ,
    .out_min(out_min),
    .out_max(out_max)
`endif
  );
  // reference: full bubble sort, returns {max, min, selected}
  function automatic logic [23:0] model(input logic [N*W-1:0] d, input logic [RW-1:0] r);
    logic [W-1:0] a [N];
    logic [W-1:0] t;
    int ri;
    for (int i = 0; i < N; i++) a[i] = d[i*W +: W];
    for (int i = 0; i < N - 1; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    ri = int'(r);
    if (ri > N - 1) ri = N - 1;
    return {a[N-1], a[0], a[ri]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sb_check(input string tag);
    logic [23:0] e;
    chk({tag, "_sb_pending"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, 32'(out), 32'(e[7:0]));
`ifdef RANK_SELECT_MINMAX_EN
      chk({tag, "_min"}, 32'(out_min), 32'(e[15:8]));
      chk({tag, "_max"}, 32'(out_max), 32'(e[23:16]));
`endif
    end
  endtask
  task automatic send(input logic [N*W-1:0] d, input logic [RW-1:0] r);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    inp = d;
    rank = r;
    in_valid = 1'b1;
    exp_q.push_back(model(d, r));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic collect(input string tag, input bit jam);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      if (jam) begin
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        inp = JUNK;
        rank = 4'd2;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(N + 1));
    if (out_valid) sb_check(tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    send(MED, 4'd4);
    collect("median", 1'b0);
    repeat (3) @(negedge clk);
    chk("median_hold", 32'(out), 32'hC9);
    send(MED, 4'd0);
    collect("rank0", 1'b0);
    send(MED, 4'd8);
    collect("rank8", 1'b0);
    send(MED, 4'd15);
    collect("rank15_clamp", 1'b0);
    send(DUP, 4'd0);
    collect("dup_rank0", 1'b0);
    send(DUP, 4'd1);
    collect("dup_rank1", 1'b0);
    send(MED, 4'd2);
    collect("busy_drop", 1'b1);
    send(DUP, 4'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    send(MED, 4'd6);
    collect("after_reset", 1'b0);
    @(negedge clk);
    inp = MED;
    rank = 4'd4;
    in_valid = 1'b1;
    exp_q.push_back(model(MED, 4'd4));
    exp_q.push_back(model(DUP, 4'd0));
    @(posedge clk);
    @(negedge clk);
    inp = DUP;
    rank = 4'd0;
    t1 = -1;
    t2 = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 11) in_valid = 1'b0;
      if (out_valid) begin
        sb_check("b2b");
        if (t1 < 0) t1 = k;
        else t2 = k;
      end
    end
    chk("b2b_first_latency", 32'(t1), 32'(N + 1));
    chk("b2b_gap", 32'(t2 - t1), 32'(N + 2));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
